// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for a shared FIFO write port.
// The winner holds the port for up to BURST_LEN beats, then the block re-arbitrates.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          busy,
  output logic [IDX_W-1:0]              owner
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] winner;
  logic             xfer;

  // Per-lane view of the packed data bus, so the write mux is a plain index.
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lanes;
  assign lanes = req_data;

  // The data path only steers by the owner register, so req_data never reaches a control output.
  assign fifo_din = lanes[owner_q];
  assign owner    = owner_q;
  assign busy     = (state_q == GRANT);

  // Cyclic priority search: first requester after the most recent owner, wrapping to 0.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[IDX_W'((int'(last_q) + i) % NUM_REQ)])
        winner = IDX_W'((int'(last_q) + i) % NUM_REQ);
    end
  end

  // Register update; synchronous reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and outputs. fifo_full only gates the write/ack strobes and the beat count.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gnt        = '0;
    ack        = '0;
    fifo_write = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = winner;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        gnt[owner_q] = 1'b1;
        xfer         = req[owner_q] && !fifo_full;
        if (!req[owner_q]) begin
          // Owner finished early; no beat this cycle.
          state_d = IDLE;
          last_d  = owner_q;
        end else if (xfer) begin
          fifo_write   = 1'b1;
          ack[owner_q] = 1'b1;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: fixed vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int DW = 8, N = 4, BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt, ack;
  logic          fifo_full, fifo_write, busy;
  logic [DW-1:0] fifo_din;
  logic [1:0]    owner;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .IDX_W(2), .BURST_LEN(BL), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_din(fifo_din),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Model state: who owns the port, who owned it last, beats taken in this burst.
  bit m_busy  = 1'b0;
  int m_owner = 0, m_last = N - 1, m_beats = 0;
  int lane_cnt [N];
  int wr_log [$];
  int n_wr = 0;
  logic [N-1:0] s_gnt;
  logic         s_busy;
  logic [1:0]   s_owner;

  function automatic logic [DW-1:0] lane_val(input int i);
    return DW'(i * 64 + (lane_cnt[i] % 64));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic f);
    rst = r; req = rq; fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = lane_val(i);
  endtask

  // One clock of model-checked traffic.
  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic f);
    logic [N-1:0] eg, ea;
    logic         ew;
    int           k;
    drive(r, rq, f);
    #4;
    eg = m_busy ? N'(1 << m_owner) : '0;
    ew = m_busy && rq[m_owner] && !f;
    ea = ew ? eg : '0;
    check("model gnt/ack/wr/busy/owner", {18'd0, gnt, ack, fifo_write, busy, owner},
          {18'd0, eg, ea, ew, m_busy, 2'(m_owner)});
    if (ew) begin
      check("model fifo_din", {24'd0, fifo_din}, {24'd0, lane_val(m_owner)});
      wr_log.push_back(m_owner);
      n_wr++;
      lane_cnt[m_owner]++;
    end
    s_gnt = gnt; s_busy = busy; s_owner = owner;
    if (r) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_beats = 0;
    end else if (!m_busy) begin
      if (rq != 0) begin
        k = (m_last + 1) % N;
        while (!rq[k]) k = (k + 1) % N;
        m_owner = k; m_beats = 0; m_busy = 1;
      end
    end else if (!rq[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (!f) begin
      m_beats++;
      if (m_beats == BL) begin m_busy = 0; m_last = m_owner; end
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic         rst;
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] gnt;
    logic [N-1:0] ack;
    logic         wr;
    logic         busy;
    logic [1:0]   owner;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int w0;
    // rst req full | gnt ack wr busy owner
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[4]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[7]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0};
    tbl[8]  = '{1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 4'b1001, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3};
    tbl[11] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    for (int i = 0; i < N; i++) lane_cnt[i] = 0;
    drive(1'b1, '0, 1'b0);
    @(posedge clk); #1;

    // Fixed vectors; lane data stays constant here.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].full);
      #4;
      check($sformatf("vec%0d", i), {19'd0, gnt, ack, fifo_write, busy, owner},
            {19'd0, tbl[i].gnt, tbl[i].ack, tbl[i].wr, tbl[i].busy, tbl[i].owner});
      if (tbl[i].wr)
        check($sformatf("vec%0d din", i), {24'd0, fifo_din}, {24'd0, lane_val(int'(tbl[i].owner))});
      @(posedge clk); #1;
    end

    // Round-robin with everyone requesting: 4 beats each, order 0,1,2,3,0.
    cycle(1'b1, 4'b0000, 1'b0);
    wr_log.delete();
    for (int c = 0; c < 22; c++) cycle(1'b0, 4'b1111, 1'b0);
    check("rr write count", 32'(wr_log.size()), 32'd17);
    for (int k = 0; k < 17 && k < wr_log.size(); k++)
      check($sformatf("rr owner of write %0d", k), 32'(wr_log[k]), 32'((k / BL) % N));

    // Back-pressure: owner 1 stalls after 2 beats, then finishes exactly 2 more.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0010, 1'b0);
    w0 = n_wr;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 4'b0010, 1'b1);
      check("full holds gnt", {28'd0, s_gnt}, 32'h2);
    end
    check("no writes while full", 32'(n_wr), 32'(w0));
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0010, 1'b0);
    check("two beats after full", 32'(n_wr), 32'(w0 + 2));
    cycle(1'b0, 4'b0000, 1'b0);
    check("released after burst", {31'd0, s_busy}, 32'd0);

    // Reset in the middle of a burst, then arbitration restarts from requester 0.
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 4'b1010, 1'b0);
    check("post-reset gnt", {28'd0, s_gnt}, 32'd0);
    check("post-reset busy", {31'd0, s_busy}, 32'd0);
    cycle(1'b0, 4'b1010, 1'b0);
    check("post-reset winner", {30'd0, s_owner}, 32'd1);
    check("post-reset winner gnt", {28'd0, s_gnt}, 32'h2);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++)
      cycle(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
